// File: rtl/jtag_ir_dr_ctrl.sv
// rtl/jtag_ir_dr_ctrl.sv - JTAG IR/DR controller with req/ack register-bus master.
// Optional feature: JTAG_CTRL_AUTOINC_EN (addr_q += 4 after each completed bus access).
module jtag_ir_dr_ctrl #(
  parameter int          IR_W       = 4,
  parameter int          ADDR_W     = 16,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int          TO_CYC     = 255
) (
  input  logic              clk,
  input  logic              trst_n,
  input  logic              tck_rise,
  input  logic              tdi_r1,
  input  logic              captureIR,
  input  logic              shiftIR,
  input  logic              updateIR,
  input  logic              captureDR,
  input  logic              shiftDR,
  input  logic              updateDR,
  output logic              tdo_mux,
  output logic              bypass,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(1);
  localparam logic [IR_W-1:0] IR_ADDR   = IR_W'(2);
  localparam logic [IR_W-1:0] IR_DATA   = IR_W'(3);
  localparam logic [IR_W-1:0] IR_STATUS = IR_W'(4);
  localparam int              AL        = ADDR_W + 1;

  typedef enum logic {S_IDLE, S_REQ} state_t;
  state_t state, state_nx;

  logic act_cir, act_sir, act_uir, act_cdr, act_sdr, act_udr;
  logic [IR_W-1:0]   ir, ir_sr;
  logic [31:0]       dr_sr, dr_shift, rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        to_cnt;
  logic              err, timeout_seen, busy;
  logic              sel_idcode, sel_addr, sel_data, sel_status;
  logic              start_rd, start_wr, start, ack_hit, to_hit, done;

  assign sel_idcode = (ir == IR_IDCODE);
  assign sel_addr   = (ir == IR_ADDR);
  assign sel_data   = (ir == IR_DATA);
  assign sel_status = (ir == IR_STATUS);
  assign bypass     = !(sel_idcode || sel_addr || sel_data || sel_status);

  assign busy     = (state == S_REQ);
  assign bus_req  = busy;
  assign start_rd = act_udr && sel_addr && dr_sr[ADDR_W];
  assign start_wr = act_udr && sel_data;
  assign start    = start_rd || start_wr;
  assign ack_hit  = busy && bus_ack;
  assign to_hit   = busy && !bus_ack && (to_cnt == 8'(TO_CYC - 1));
  assign done     = ack_hit || to_hit;

  // TDI enters at the MSB of the selected length; ADDR uses a short {rd, addr} chain.
  always_comb begin
    dr_shift = {tdi_r1, dr_sr[31:1]};
    if (sel_addr) begin
      dr_shift        = 32'(dr_sr[AL-1:1]);
      dr_shift[AL-1]  = tdi_r1;
    end
  end

  always_ff @(posedge clk) begin
    if (!trst_n) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_REQ;
      S_REQ:   if (done)  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!trst_n) begin
      {act_cir, act_sir, act_uir, act_cdr, act_sdr, act_udr} <= '0;
      ir           <= IR_IDCODE;
      ir_sr        <= IR_IDCODE;
      dr_sr        <= '0;
      addr_q       <= '0;
      rdata_q      <= '0;
      tdo_mux      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      to_cnt       <= '0;
      err          <= 1'b0;
      timeout_seen <= 1'b0;
    end else begin
      // Flags describe the state before the TCK edge; act on them one clk later.
      if (tck_rise)
        {act_cir, act_sir, act_uir, act_cdr, act_sdr, act_udr} <=
          {captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR};
      else
        {act_cir, act_sir, act_uir, act_cdr, act_sdr, act_udr} <= '0;

      tdo_mux <= shiftIR ? ir_sr[0] : dr_sr[0];

      if (act_cir)      ir_sr <= IR_W'({err, busy, 2'b01});
      else if (act_sir) ir_sr <= {tdi_r1, ir_sr[IR_W-1:1]};
      if (act_uir)      ir <= ir_sr;

      if (act_cdr) begin
        if (sel_idcode)      dr_sr <= IDCODE_VAL;
        else if (sel_addr)   dr_sr <= 32'(addr_q);
        else if (sel_data)   dr_sr <= rdata_q;
        else if (sel_status) dr_sr <= {28'b0, timeout_seen, err, busy, 1'b1};
      end else if (act_sdr && !bypass) begin
        dr_sr <= dr_shift;
      end

      if (!busy && start) begin
        bus_we   <= start_wr;
        bus_addr <= start_wr ? addr_q : dr_sr[ADDR_W-1:0];
        if (start_wr) bus_wdata <= dr_sr;
        to_cnt   <= '0;
      end else if (busy && !bus_ack) begin
        to_cnt <= to_cnt + 8'd1;
      end

      if (ack_hit && !bus_we) rdata_q <= bus_rdata;
      if (to_hit && !bus_we)  rdata_q <= 32'hDEAD_BEEF;

      // Clear first so a same-clk timeout or discard still leaves the flags set.
      if (act_udr && sel_status && dr_sr[1]) begin
        err          <= 1'b0;
        timeout_seen <= 1'b0;
      end
      if (to_hit) begin
        err          <= 1'b1;
        timeout_seen <= 1'b1;
      end
      if (busy && start) err <= 1'b1;

`ifdef JTAG_CTRL_AUTOINC_EN
      if (done) addr_q <= addr_q + ADDR_W'(4);
`endif
      if (act_udr && sel_addr) addr_q <= dr_sr[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_jtag_ir_dr_ctrl.sv
// tb/tb_jtag_ir_dr_ctrl.sv - scoreboard bench for jtag_ir_dr_ctrl with a transaction-level model.
module tb_jtag_ir_dr_ctrl;
  localparam int          IR_W   = 4;
  localparam int          ADDR_W = 16;
  localparam int          TO_CYC = 255;
  localparam logic [31:0] IDV    = 32'h1000_0001;

  localparam logic [5:0] F_NONE = 6'b000000, F_CIR = 6'b100000, F_SIR = 6'b010000,
                         F_UIR  = 6'b001000, F_CDR = 6'b000100, F_SDR = 6'b000010,
                         F_UDR  = 6'b000001;

  logic clk, trst_n, tck_rise, tdi_r1;
  logic captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR;
  logic tdo_mux, bypass, bus_req, bus_we, bus_ack;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;

  jtag_ir_dr_ctrl dut (
    .clk(clk), .trst_n(trst_n), .tck_rise(tck_rise), .tdi_r1(tdi_r1),
    .captureIR(captureIR), .shiftIR(shiftIR), .updateIR(updateIR),
    .captureDR(captureDR), .shiftDR(shiftDR), .updateDR(updateDR),
    .tdo_mux(tdo_mux), .bypass(bypass), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rsp;
    int          delay;
    bit          withhold;
    bit          abort;
  } txn_t;
  typedef struct {
    logic [31:0] val;
    int          len;
  } scan_t;

  txn_t  bus_q[$];
  scan_t scan_q[$];
  int checks = 0, fails = 0, n_txn = 0, n_exp = 0;

  // Transaction-level model of the controller's architectural state.
  logic [3:0]  m_ir;
  logic [15:0] m_addr;
  logic [31:0] m_rdata;
  logic        m_err, m_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ir = 4'd1; m_addr = '0; m_rdata = '0; m_err = 1'b0; m_to = 1'b0;
  endtask

  task automatic autoinc();
`ifdef JTAG_CTRL_AUTOINC_EN
    m_addr = m_addr + 16'd4;
`endif
  endtask

  task automatic tck(input logic [5:0] f, input logic d);
    {captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR} = f;
    tdi_r1 = d;
    tck_rise = 1'b0;
    repeat (3) @(posedge clk);
    #1 tck_rise = 1'b1;
    @(posedge clk);
    #1 tck_rise = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic scan_ir(input logic [3:0] code);
    scan_t e;
    e.val = 32'({m_err, 1'b0, 2'b01});
    e.len = IR_W;
    scan_q.push_back(e);
    tck(F_CIR, 1'b0);
    for (int i = 0; i < IR_W; i++) tck(F_SIR, code[i]);
    tck(F_NONE, 1'b0);
    tck(F_UIR, 1'b0);
    tck(F_NONE, 1'b0);
    m_ir = code;
    check("bypass", 32'(bypass), (code inside {4'd1, 4'd2, 4'd3, 4'd4}) ? 32'd0 : 32'd1);
  endtask

  task automatic scan_dr(input logic [31:0] din);
    scan_t e;
    case (m_ir)
      4'd1:    begin e.val = IDV;                                    e.len = 32;       end
      4'd2:    begin e.val = 32'(m_addr);                            e.len = ADDR_W+1; end
      4'd3:    begin e.val = m_rdata;                                e.len = 32;       end
      4'd4:    begin e.val = {28'b0, m_to, m_err, 1'b0, 1'b1};      e.len = 32;       end
      default: begin e.val = '0;                                     e.len = 0;        end
    endcase
    if (e.len > 0) scan_q.push_back(e);
    tck(F_CDR, 1'b0);
    for (int i = 0; i < e.len; i++) tck(F_SDR, din[i]);
    tck(F_NONE, 1'b0);
    tck(F_UDR, 1'b0);
    tck(F_NONE, 1'b0);
  endtask

  task automatic push_txn(input logic we, input logic [15:0] a, input logic [31:0] wd,
                          input logic [31:0] rsp, input int dly, input bit wh, input bit ab);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = wd; t.rsp = rsp;
    t.delay = dly; t.withhold = wh; t.abort = ab;
    bus_q.push_back(t);
    n_exp++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus_req || bus_q.size() != 0) && n < 1000) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 1000) begin
      checks++; fails++;
      $display("FAIL bus_idle: still busy after %0d clk, required idle", n);
      bus_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_addr(input logic rd, input logic [15:0] a, input logic [31:0] rsp,
                         input int dly, input bit wh);
    if (m_ir != 4'd2) scan_ir(4'd2);
    if (rd) push_txn(1'b0, a, '0, rsp, dly, wh, 1'b0);
    scan_dr({15'b0, rd, a});
    m_addr = a;
    if (rd) begin
      wait_idle();
      if (wh) begin m_rdata = 32'hDEAD_BEEF; m_err = 1'b1; m_to = 1'b1; end
      else    m_rdata = rsp;
      autoinc();
    end
  endtask

  task automatic do_data(input logic [31:0] wd, input int dly, input bit wh);
    if (m_ir != 4'd3) scan_ir(4'd3);
    push_txn(1'b1, m_addr, wd, '0, dly, wh, 1'b0);
    scan_dr(wd);
    wait_idle();
    if (wh) begin m_err = 1'b1; m_to = 1'b1; end
    autoinc();
  endtask

  task automatic do_status(input logic [31:0] din);
    if (m_ir != 4'd4) scan_ir(4'd4);
    scan_dr(din);
    if (din[1]) begin m_err = 1'b0; m_to = 1'b0; end
  endtask

  task automatic do_idcode(input logic [31:0] din);
    if (m_ir != 4'd1) scan_ir(4'd1);
    scan_dr(din);
  endtask

  // Scan monitor: collects TDO while in a shift state, compares when the shift ends.
  initial begin
    logic [31:0] sbuf, mask;
    int nb;
    scan_t e;
    sbuf = '0;
    nb = 0;
    forever begin
      @(negedge clk);
      if (tck_rise) begin
        if (shiftDR || shiftIR) begin
          if (nb < 32) sbuf[nb] = tdo_mux;
          nb++;
        end else if (nb > 0) begin
          if (scan_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL scan_unexpected: %0d bits %h, required no scan", nb, sbuf);
          end else begin
            e = scan_q.pop_front();
            mask = (e.len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << e.len) - 32'd1);
            check("scan_len", 32'(nb), 32'(e.len));
            check("scan_data", sbuf & mask, e.val);
          end
          nb = 0;
          sbuf = '0;
        end
      end
    end
  end

  // Bus monitor and responder.
  initial begin
    txn_t t;
    int c;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_req) begin
        n_txn++;
        if (bus_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL txn_unexpected: we=%b addr=%h wdata=%h", bus_we, bus_addr, bus_wdata);
          c = 0;
          while (bus_req && c < TO_CYC + 20) begin c++; @(posedge clk); #1; end
        end else begin
          t = bus_q.pop_front();
          check("txn_we", 32'(bus_we), 32'(t.we));
          check("txn_addr", 32'(bus_addr), 32'(t.addr));
          if (t.we) check("txn_wdata", bus_wdata, t.wdata);
          if (t.withhold) begin
            c = 0;
            while (bus_req && c < TO_CYC + 20) begin c++; @(posedge clk); #1; end
            if (!t.abort) check("timeout_len", 32'(c), 32'(TO_CYC));
          end else begin
            repeat (t.delay) @(posedge clk);
            #1 bus_ack = 1'b1;
            bus_rdata = t.rsp;
            @(posedge clk);
            #1 bus_ack = 1'b0;
            bus_rdata = $urandom;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    fails++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    int hi;
    logic [3:0] c;
    trst_n = 1'b0; tck_rise = 1'b0; tdi_r1 = 1'b0;
    {captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR} = F_NONE;
    model_reset();
    repeat (4) @(posedge clk);
    #1 trst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tdo", 32'(tdo_mux), 32'd0);
    check("rst_bypass", 32'(bypass), 32'd0);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_addr", 32'(bus_addr), 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);

    do_idcode(32'h0);
    scan_ir(4'hF);
    do_addr(1'b1, 16'h0040, 32'hCAFE_0123, 5, 1'b0);
    do_data(32'h0BAD_F00D, 2, 1'b0);
    do_addr(1'b0, 16'h0010, '0, 0, 1'b0);
    do_data(32'h1234_5678, 3, 1'b0);
    do_data(32'h8765_4321, 1, 1'b0);
    do_addr(1'b1, 16'h0020, '0, 0, 1'b1);
    do_status(32'h0000_0002);
    do_status(32'h0000_0000);
    do_data(32'h5555_AAAA, 4, 1'b0);

    // Second DATA update lands while the first write is still waiting for ack.
    do_addr(1'b0, 16'h0010, '0, 0, 1'b0);
    if (m_ir != 4'd3) scan_ir(4'd3);
    push_txn(1'b1, m_addr, 32'hA5A5_0001, '0, 240, 1'b0, 1'b0);
    scan_dr(32'hA5A5_0001);
    scan_dr(32'hA5A5_0002);
    m_err = 1'b1;
    wait_idle();
    autoinc();
    do_status(32'h0000_0000);
    do_status(32'h0000_0002);

    for (int k = 0; k < 14; k++) begin
      case ($urandom_range(0, 5))
        0: begin
          do_addr(1'b0, 16'($urandom), '0, 0, 1'b0);
          do_data($urandom, $urandom_range(1, 20), 1'b0);
        end
        1: do_addr(1'b1, 16'($urandom), $urandom, $urandom_range(1, 30), $urandom_range(0, 4) == 0);
        2: do_data($urandom, $urandom_range(1, 20), $urandom_range(0, 5) == 0);
        3: do_status($urandom);
        4: do_idcode($urandom);
        default: begin
          c = 4'($urandom_range(5, 15));
          if ($urandom_range(0, 1) == 1) c = 4'd0;
          scan_ir(c);
        end
      endcase
    end

    // Reset in the middle of a pending read abandons it.
    if (m_ir != 4'd2) scan_ir(4'd2);
    push_txn(1'b0, 16'h0100, '0, '0, 1, 1'b1, 1'b1);
    scan_dr({15'b0, 1'b1, 16'h0100});
    repeat (20) @(posedge clk);
    #1 trst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 trst_n = 1'b1;
    model_reset();
    hi = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus_req) hi++;
    end
    check("req_after_reset", 32'(hi), 32'd0);
    check("bypass_after_reset", 32'(bypass), 32'd0);
    do_idcode($urandom);
    do_status(32'h0);

    repeat (10) @(posedge clk);
    #1;
    check("txn_count", 32'(n_txn), 32'(n_exp));
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    check("scan_q_empty", 32'(scan_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
